amba_decoder_mux: RTL and testbench
===================================

// Module: amba_decoder_mux
// PURPOSE
//  AHB-Lite single-master interconnect stage: decodes master address-phase haddr into one-hot hsel for
//  NSLV slaves (amba_slave_mem instances etc.), muxes data-phase hrdata/hresp/hreadyout back to master,
//  broadcasts combined hready. Unmapped accesses answered by internal default slave (two-cycle ERROR).
// PARAMETERS
//  NSLV        4    number of attached slaves, 1..2**SEL_BITS-1
//  SEL_BITS    4    haddr MSBs used as slave index: idx = haddr[AWIDTH-1 -: SEL_BITS]
//  TIMEOUT_CYC 16   wait-state limit before forced ERROR (only with AHB_DEC_TIMEOUT_EN)
// PORTS
//  clk          in   1               clock, single domain
//  rst_n        in   1               asynchronous active-low reset
//  haddr        in   AWIDTH          master address
//  htrans       in   2               master transfer type
//  hready       out  1               combined ready to master AND broadcast to all slaves' hready
//  hresp        out  1               muxed response to master
//  hrdata       out  DWIDTH          muxed read data to master
//  hsel         out  NSLV            one-hot slave select, combinational from haddr
//  hreadyout_s  in   NSLV            per-slave hreadyout
//  hresp_s      in   NSLV            per-slave hresp
//  hrdata_s     in   NSLV*DWIDTH     per-slave hrdata, slave i at [i*DWIDTH +: DWIDTH]
// BEHAVIOUR
//  Decode: idx<NSLV -> hsel[idx]=1; else hsel=0 and default slave selected. Pure comb, no htrans gating.
//  Data-phase select dsel_q (idx or DEFAULT) captured at posedge when hready=1; held while hready=0.
//  Reset: dsel_q=DEFAULT, default FSM=IDLE -> hready=1, hresp=HRESP_OKAY, hrdata=0 out of reset.
//  Mux: dsel_q=i -> hready=hreadyout_s[i], hresp=hresp_s[i], hrdata=slice i. dsel_q=DEFAULT -> FSM outs,
//   hrdata=0. Latency: zero added cycles; slave wait states pass straight through.
//  Default slave FSM (states IDLE, ERR1, ERR2):
//   IDLE: hreadyout=1,hresp=OKAY. Go ERR1 when hready=1, unmapped idx, htrans[1]=1 (NONSEQ/SEQ).
//   ERR1: hreadyout=0,hresp=ERROR -> ERR2 unconditionally.
//   ERR2: hreadyout=1,hresp=ERROR -> ERR1 if new unmapped NONSEQ/SEQ captured, else IDLE.
//   IDLE/BUSY to unmapped: zero-wait OKAY, no ERROR.
//  Back-to-back: pipelined transfers to different slaves legal; mux always follows dsel_q (data phase),
//   hsel follows haddr (address phase) in same cycle.
//  Reset mid-transfer: async clear to reset state regardless of pending wait states or ERR1/ERR2.
// CONFIGURATION
//  AHB_DEC_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYC+1)) cleared when hready=1,
//   increments each cycle dsel_q!=DEFAULT and hready=0. On reaching TIMEOUT_CYC, master side overridden
//   by two-cycle ERROR (cycle1 hready=0/ERROR, cycle2 hready=1/ERROR, hrdata=0); second cycle's hready=1
//   also broadcast to slaves, terminating their transfer. Counter clears on override completion.
//  Not defined: no counter, no override; stalled slave stalls bus indefinitely.
// STRUCTURE
//  amba_pkg: AWIDTH, DWIDTH, HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY=0/HRESP_ERROR=1,
//   dflt_state_t enum {IDLE,ERR1,ERR2}.
//  Sub-module amba_default_slave: standard AHB slave port (hsel,htrans,hready,hreadyout,hresp),
//   contains the IDLE/ERR1/ERR2 FSM; decoder drives its hsel=unmapped.
// TESTING (NSLV=4, slaves = amba_slave_mem with 2 wait states)
//  1 Reset: assert rst_n=0 mid-wait -> hready=1, hresp=OKAY, hrdata=0, FSM IDLE within same cycle.
//  2 Write word 0xDEADBEEF idx 2 offset 0x10, then read it -> hsel=4'b0100, 2 wait cycles each, read
//    returns 0xDEADBEEF, hresp from slave 2.
//  3 NONSEQ read idx 7 -> hsel=0, next cycle hready=0/ERROR, then hready=1/ERROR, then OKAY.
//  4 IDLE to idx 7 -> hready stays 1, hresp=OKAY, no ERROR cycles.
//  5 Pipelined write idx0 then read idx1 (haddr idx1 during idx0 data phase) -> hsel=0010 while
//    mux reports slave0 ready; read data from slave1 after its 2 waits; no cross-slave corruption.
//  6 AHB_DEC_TIMEOUT_EN, TIMEOUT_CYC=16, slave hreadyout tied 0 -> 16 stall cycles, then 2-cycle ERROR,
//    hready=1 at cycle 18; without macro hready stays 0 for >=100 cycles.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AHB-Lite definitions for the decoder/mux interconnect stage:
// bus widths, transfer-type and response encodings, default-slave states.
package amba_pkg;

  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } dflt_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a real response;
  // IDLE and BUSY always get a zero-wait OKAY.
  function automatic logic xfer_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/amba_decoder_mux_default_slave.sv
// Default slave for the AHB-Lite decoder: answers any active transfer to an
// unmapped region with the standard two-cycle ERROR response and anything
// else with a zero-wait OKAY. Outputs are registered straight from the FSM.
module amba_default_slave
  import amba_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       hreadyout,
  output logic       hresp
);

  dflt_state_t state_q;
  logic        start_err;

  // A new ERROR sequence starts only when an active transfer to us is
  // actually accepted on the bus (hready high at the sampling edge).
  assign start_err = hsel && hready && xfer_active(htrans);

  // Single FSM: IDLE -> ERR1 (stall, ERROR) -> ERR2 (complete, ERROR) -> IDLE/ERR1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_err) begin
            state_q   <= ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end else begin
            state_q   <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
        ERR1: begin
          state_q   <= ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        ERR2: begin
          if (start_err) begin
            state_q   <= ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end else begin
            state_q   <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
        default: begin
          state_q   <= IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/amba_decoder_mux.sv
// AHB-Lite single-master interconnect stage. Decodes the address-phase haddr
// MSBs into a one-hot hsel, then steers the selected slave's data-phase
// hready/hresp/hrdata back to the master. Unmapped regions are served by an
// internal default slave that returns a two-cycle ERROR.
//
// Optional build macro AHB_DEC_TIMEOUT_EN: adds a wait-state watchdog that
// forces a two-cycle ERROR to the master after TIMEOUT_CYC stalled cycles.
module amba_decoder_mux
  import amba_pkg::*;
#(
  parameter int NSLV        = 4,
  parameter int SEL_BITS    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AWIDTH-1:0]      haddr,
  input  logic [1:0]             htrans,
  output logic                   hready,
  output logic                   hresp,
  output logic [DWIDTH-1:0]      hrdata,
  output logic [NSLV-1:0]        hsel,
  input  logic [NSLV-1:0]        hreadyout_s,
  input  logic [NSLV-1:0]        hresp_s,
  input  logic [NSLV*DWIDTH-1:0] hrdata_s
);

  // The all-ones index can never be a mapped slave (NSLV <= 2**SEL_BITS-1),
  // so it doubles as the "default slave" marker in the data-phase select.
  localparam logic [SEL_BITS-1:0] DFLT_IDX = '1;
  localparam logic [SEL_BITS-1:0] NSLV_L   = SEL_BITS'(NSLV);

  logic [SEL_BITS-1:0] idx;
  logic                mapped;
  logic [SEL_BITS-1:0] dsel_q;
  logic                dflt_hreadyout;
  logic                dflt_hresp;
  logic                slv_ready;
  logic                slv_resp;
  logic [DWIDTH-1:0]   slv_rdata;
  logic                unused_addr_lsbs;

  assign idx              = haddr[AWIDTH-1 -: SEL_BITS];
  assign mapped           = (idx < NSLV_L);
  assign unused_addr_lsbs = ^haddr[AWIDTH-SEL_BITS-1:0];

  // Address-phase decode: one-hot select straight from haddr, no htrans gating
  always_comb begin
    hsel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SEL_BITS'(i)) begin
        hsel[i] = 1'b1;
      end
    end
  end

  // Data-phase select: advances only when the current transfer completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel_q <= DFLT_IDX;
    end else if (hready) begin
      dsel_q <= mapped ? idx : DFLT_IDX;
    end
  end

  amba_default_slave u_dflt (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsel      (~mapped),
    .htrans    (htrans),
    .hready    (hready),
    .hreadyout (dflt_hreadyout),
    .hresp     (dflt_hresp)
  );

  // Response mux: follows the data-phase owner, default slave reads as zero
  always_comb begin
    slv_ready = dflt_hreadyout;
    slv_resp  = dflt_hresp;
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q == SEL_BITS'(i)) begin
        slv_ready = hreadyout_s[i];
        slv_resp  = hresp_s[i];
        slv_rdata = hrdata_s[i*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt_q;
  logic             ovr_err1;
  logic             ovr_err2_q;

  // Reaching the limit starts the first (stalling) cycle of the forced ERROR
  assign ovr_err1 = (to_cnt_q == CNT_LIMIT);

  // Watchdog: count stalled cycles owned by a real slave; the second ERROR
  // cycle always follows the first, and its hready=1 clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q   <= '0;
      ovr_err2_q <= 1'b0;
    end else begin
      ovr_err2_q <= ovr_err1;
      if (hready || ovr_err1) begin
        to_cnt_q <= '0;
      end else if (dsel_q != DFLT_IDX) begin
        to_cnt_q <= to_cnt_q + CNT_W'(1);
      end
    end
  end

  // Master-side outputs, overridden by the forced ERROR sequence when it fires
  always_comb begin
    hready = slv_ready;
    hresp  = slv_resp;
    hrdata = slv_rdata;
    if (ovr_err1) begin
      hready = 1'b0;
      hresp  = HRESP_ERROR;
      hrdata = '0;
    end else if (ovr_err2_q) begin
      hready = 1'b1;
      hresp  = HRESP_ERROR;
      hrdata = '0;
    end
  end
`else
  // Master-side outputs come straight from the selected slave
  always_comb begin
    hready = slv_ready;
    hresp  = slv_resp;
    hrdata = slv_rdata;
  end
`endif

endmodule

// File: tb/tb_amba_decoder_mux.sv
// Self-checking bench for amba_decoder_mux with four behavioural memory
// slaves (two wait states each). Honour AHB_DEC_TIMEOUT_EN when defined.
module tb_amba_decoder_mux;
  import amba_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [31:0]  hwdata;
  logic         hready;
  logic         hresp;
  logic [31:0]  hrdata;
  logic [3:0]   hsel;
  logic [3:0]   hreadyout_s;
  logic [3:0]   hresp_s;
  logic [127:0] hrdata_s;
  logic         stall_en;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  amba_decoder_mux #(.NSLV(4), .SEL_BITS(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .haddr       (haddr),
    .htrans      (htrans),
    .hready      (hready),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .hsel        (hsel),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hrdata_s    (hrdata_s)
  );

  // Behavioural slave memories: capture on accepted NONSEQ/SEQ, two waits
  logic [3:0]  s_act;
  logic [3:0]  s_wr;
  logic [3:0]  s_addr [4];
  logic [1:0]  s_wcnt [4];
  logic [31:0] s_mem  [4][16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        s_act[i]  <= 1'b0;
        s_wr[i]   <= 1'b0;
        s_addr[i] <= '0;
        s_wcnt[i] <= '0;
        for (int j = 0; j < 16; j++) s_mem[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hready) begin
          if (s_act[i] && s_wr[i] && hreadyout_s[i]) s_mem[i][s_addr[i]] <= hwdata;
          s_act[i]  <= hsel[i] && htrans[1];
          s_wr[i]   <= hwrite;
          s_addr[i] <= haddr[5:2];
          s_wcnt[i] <= '0;
        end else if (s_act[i] && s_wcnt[i] != 2'd2) begin
          s_wcnt[i] <= s_wcnt[i] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    hrdata_s = '0;
    hresp_s  = '0;
    for (int i = 0; i < 4; i++) begin
      hreadyout_s[i] = !s_act[i] || (s_wcnt[i] == 2'd2);
      if (stall_en && i == 3) hreadyout_s[i] = 1'b0;
      if (s_act[i] && !s_wr[i]) hrdata_s[i*32 +: 32] = s_mem[i][s_addr[i]];
    end
  end

  task automatic go_idle();
    haddr  = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Waits for hready in the data phase; returns at the negedge where it is high
  task automatic wait_ready(output int waits);
    bit done;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (hready) done = 1;
      else begin
        waits++;
        if (waits > 40) begin
          n_cmp++; n_fail++;
          $display("[TB] FAIL ready_timeout got waits=%0d exp<=40", waits);
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                         output logic [3:0] sel, output int waits,
                         output logic [31:0] rdata, output logic resp);
    haddr = addr; htrans = HTRANS_NONSEQ; hwrite = write; hwdata = '0;
    @(negedge clk);
    sel = hsel;
    @(posedge clk); #1;
    go_idle();
    hwdata = wdata;
    wait_ready(waits);
    rdata = hrdata;
    resp  = hresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_en = 1'b0; hwdata = '0; go_idle();
    #2;
    n_cmp++; if (hready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_hready got=%b exp=1", hready); end
    n_cmp++; if (hresp !== HRESP_OKAY) begin n_fail++; $display("[TB] FAIL rst_hresp got=%b exp=0", hresp); end
    n_cmp++; if (hrdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_hrdata got=%h exp=0", hrdata); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // reset asserted while slave 2 is inserting wait states
    haddr = 32'h2000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    n_cmp++; if (hready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pre_wait got=%b exp=0", hready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (hready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_midwait_hready got=%b exp=1", hready); end
    n_cmp++; if (hrdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_midwait_hrdata got=%h exp=0", hrdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    // reset asserted during ERR1 of the default slave
    haddr = 32'h7000_0000; htrans = HTRANS_NONSEQ;
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    n_cmp++; if (hresp !== HRESP_ERROR) begin n_fail++; $display("[TB] FAIL rst_pre_err1 got=%b exp=1", hresp); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (hready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_err1_hready got=%b exp=1", hready); end
    n_cmp++; if (hresp !== HRESP_OKAY) begin n_fail++; $display("[TB] FAIL rst_err1_hresp got=%b exp=0", hresp); end
    n_cmp++; if (dut.u_dflt.state_q !== IDLE) begin n_fail++; $display("[TB] FAIL rst_err1_state got=%0d exp=0", dut.u_dflt.state_q); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_read_write();
    logic [3:0] sel; int waits; logic [31:0] rd; logic rsp;
    do_xfer(32'h2000_0010, 1'b1, 32'hDEAD_BEEF, sel, waits, rd, rsp);
    n_cmp++; if (sel !== 4'b0100) begin n_fail++; $display("[TB] FAIL wr_hsel got=%b exp=0100", sel); end
    n_cmp++; if (waits != 2) begin n_fail++; $display("[TB] FAIL wr_waits got=%0d exp=2", waits); end
    n_cmp++; if (rsp !== HRESP_OKAY) begin n_fail++; $display("[TB] FAIL wr_hresp got=%b exp=0", rsp); end
    do_xfer(32'h2000_0010, 1'b0, 32'h0, sel, waits, rd, rsp);
    n_cmp++; if (sel !== 4'b0100) begin n_fail++; $display("[TB] FAIL rd_hsel got=%b exp=0100", sel); end
    n_cmp++; if (waits != 2) begin n_fail++; $display("[TB] FAIL rd_waits got=%0d exp=2", waits); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", rd); end
    n_cmp++; if (rsp !== HRESP_OKAY) begin n_fail++; $display("[TB] FAIL rd_hresp got=%b exp=0", rsp); end
    // highest mapped slave, also preloads data used by the stall scenario
    do_xfer(32'h3000_0000, 1'b1, 32'hCAFE_0003, sel, waits, rd, rsp);
    n_cmp++; if (sel !== 4'b1000) begin n_fail++; $display("[TB] FAIL wr3_hsel got=%b exp=1000", sel); end
    do_xfer(32'h3000_0000, 1'b0, 32'h0, sel, waits, rd, rsp);
    n_cmp++; if (rd !== 32'hCAFE_0003) begin n_fail++; $display("[TB] FAIL rd3_data got=%h exp=cafe0003", rd); end
  endtask

  task automatic test_unmapped();
    haddr = 32'h7000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (hsel !== 4'b0000) begin n_fail++; $display("[TB] FAIL um_hsel got=%b exp=0000", hsel); end
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b01) begin n_fail++; $display("[TB] FAIL um_err1 got=%b exp=01", {hready, hresp}); end
    // ERR2 cycle, with a new unmapped SEQ (boundary idx 4) driven alongside
    @(posedge clk); #1;
    haddr = 32'h4000_0000; htrans = HTRANS_SEQ;
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b11) begin n_fail++; $display("[TB] FAIL um_err2 got=%b exp=11", {hready, hresp}); end
    n_cmp++; if (hsel !== 4'b0000) begin n_fail++; $display("[TB] FAIL um_idx4_hsel got=%b exp=0000", hsel); end
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b01) begin n_fail++; $display("[TB] FAIL um_b2b_err1 got=%b exp=01", {hready, hresp}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b11) begin n_fail++; $display("[TB] FAIL um_b2b_err2 got=%b exp=11", {hready, hresp}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("[TB] FAIL um_okay got=%b exp=10", {hready, hresp}); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_unmapped();
    logic [1:0] trans_tab [3];
    trans_tab[0] = HTRANS_IDLE; trans_tab[1] = HTRANS_BUSY; trans_tab[2] = HTRANS_IDLE;
    for (int k = 0; k < 3; k++) begin
      haddr = 32'h7000_0000; htrans = trans_tab[k];
      @(negedge clk);
      n_cmp++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("[TB] FAIL idle_um_%0d got=%b exp=10", k, {hready, hresp}); end
      @(posedge clk); #1;
    end
    go_idle();
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("[TB] FAIL idle_um_after got=%b exp=10", {hready, hresp}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] sel; int waits; logic [31:0] rd; logic rsp;
    do_xfer(32'h1000_0004, 1'b1, 32'h1234_5678, sel, waits, rd, rsp);
    haddr = 32'h0000_0004; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    @(negedge clk);
    n_cmp++; if (hsel !== 4'b0001) begin n_fail++; $display("[TB] FAIL b2b_hsel0 got=%b exp=0001", hsel); end
    @(posedge clk); #1;
    haddr = 32'h1000_0004; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hwdata = 32'hA5A5_0000;
    wait_ready(waits);
    n_cmp++; if (waits != 2) begin n_fail++; $display("[TB] FAIL b2b_wr_waits got=%0d exp=2", waits); end
    n_cmp++; if (hsel !== 4'b0010) begin n_fail++; $display("[TB] FAIL b2b_hsel1 got=%b exp=0010", hsel); end
    @(posedge clk); #1; go_idle(); hwdata = '0;
    wait_ready(waits);
    n_cmp++; if (waits != 2) begin n_fail++; $display("[TB] FAIL b2b_rd_waits got=%0d exp=2", waits); end
    n_cmp++; if (hrdata !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL b2b_rd_data got=%h exp=12345678", hrdata); end
    @(posedge clk); #1;
    do_xfer(32'h0000_0004, 1'b0, 32'h0, sel, waits, rd, rsp);
    n_cmp++; if (rd !== 32'hA5A5_0000) begin n_fail++; $display("[TB] FAIL b2b_s0_data got=%h exp=a5a50000", rd); end
    do_xfer(32'h1000_0004, 1'b0, 32'h0, sel, waits, rd, rsp);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL b2b_s1_intact got=%h exp=12345678", rd); end
  endtask

  task automatic test_stall();
    logic        rdy [1:100];
    logic        rsp [1:100];
    logic [31:0] rdv [1:100];
    int          bad;
    stall_en = 1'b1;
    haddr = 32'h3000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
    @(posedge clk); #1; go_idle();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      rdy[c] = hready; rsp[c] = hresp; rdv[c] = hrdata;
      @(posedge clk); #1;
`ifdef AHB_DEC_TIMEOUT_EN
      if (c == 18) break;
`endif
    end
`ifdef AHB_DEC_TIMEOUT_EN
    bad = 0;
    for (int c = 1; c <= 16; c++) if (rdy[c] !== 1'b0 || rsp[c] !== HRESP_OKAY) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("[TB] FAIL to_stall_cycles got_bad=%0d exp=0", bad); end
    n_cmp++; if (rdv[16] !== 32'hCAFE_0003) begin n_fail++; $display("[TB] FAIL to_stall_data got=%h exp=cafe0003", rdv[16]); end
    n_cmp++; if ({rdy[17], rsp[17]} !== 2'b01) begin n_fail++; $display("[TB] FAIL to_ovr1 got=%b exp=01", {rdy[17], rsp[17]}); end
    n_cmp++; if ({rdy[18], rsp[18]} !== 2'b11) begin n_fail++; $display("[TB] FAIL to_ovr2 got=%b exp=11", {rdy[18], rsp[18]}); end
    n_cmp++; if (rdv[18] !== 32'h0) begin n_fail++; $display("[TB] FAIL to_ovr2_data got=%h exp=0", rdv[18]); end
    stall_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("[TB] FAIL to_after got=%b exp=10", {hready, hresp}); end
    @(posedge clk); #1;
`else
    bad = 0;
    for (int c = 1; c <= 100; c++) if (rdy[c] !== 1'b0) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("[TB] FAIL stall_hold got_ready_cycles=%0d exp=0", bad); end
    n_cmp++; if (rdv[100] !== 32'hCAFE_0003) begin n_fail++; $display("[TB] FAIL stall_data got=%h exp=cafe0003", rdv[100]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (hready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_rst_hready got=%b exp=1", hready); end
    stall_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_unmapped();
    test_idle_unmapped();
    test_back_to_back();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
